// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM states, default base address and byte-lane helpers for wb_host_bridge
package wb_pkg;
  typedef enum logic {IDLE, BUS} state_t;
  localparam logic [31:0] WB_BASE_ADDR = 32'h3000_0000;
  function automatic logic [3:0] lane_sel(input logic [1:0] a);
    return 4'b0001 << a;
  endfunction
  function automatic logic [7:0] lane_get(input logic [31:0] d, input logic [1:0] a);
    return d[{a, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr: cycle counter (clk, rst, clr, en) flagging expired on the last allowed wait cycle; TIMEOUT=0 disables
module wb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expired = TIMEOUT != 0 && cnt == LAST;
endmodule

// File: rtl/wb_host_bridge.sv
// wb_host_bridge: 8-bit valid/ready host requests -> single 32-bit Wishbone B4 classic cycles (req_*, rsp_*, wbm_*), with timeout abort
module wb_host_bridge
  import wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = WB_BASE_ADDR,
  parameter int          ADDR_W    = 16,
  parameter int          TIMEOUT   = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [31:0]       wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  output logic [3:0]        wbm_sel_o,
  input  logic [31:0]       wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i
);
  state_t      state, state_d;
  logic        cyc_d, we_d, ready_d, rsp_valid_d, rsp_err_d, expired;
  logic [31:0] adr_d, dat_d;
  logic [3:0]  sel_d;
  logic [7:0]  rdata_d;
  logic [1:0]  lane, lane_d;
  logic        accept, done, fail;
  // req_ready is low for one edge after reset release, so gating accept on it
  // keeps that first edge from starting a cycle.
  assign accept = state == IDLE && req_valid && req_ready;
  assign fail   = wbm_err_i || (!wbm_ack_i && expired);
  assign done   = state == BUS && (wbm_ack_i || fail);
  wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(wb_clk_i), .rst(wb_rst_i), .clr(accept),
    .en(state == BUS && !wbm_ack_i && !wbm_err_i), .expired(expired)
  );
  always_comb begin
    state_d     = state;
    cyc_d       = wbm_cyc_o;
    we_d        = wbm_we_o;
    adr_d       = wbm_adr_o;
    dat_d       = wbm_dat_o;
    sel_d       = wbm_sel_o;
    lane_d      = lane;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err;
    rdata_d     = rsp_rdata;
    if (accept) begin
      state_d = BUS;
      cyc_d   = 1'b1;
      we_d    = req_we;
      adr_d   = BASE_ADDR | 32'({req_addr[ADDR_W-1:2], 2'b00});
      dat_d   = {4{req_wdata}};
      sel_d   = lane_sel(req_addr[1:0]);
      lane_d  = req_addr[1:0];
    end else if (done) begin
      state_d     = IDLE;
      cyc_d       = 1'b0;
      we_d        = 1'b0;
      sel_d       = 4'b0000;
      rsp_valid_d = 1'b1;
      rsp_err_d   = fail;
      rdata_d     = fail ? 8'hFF : wbm_we_o ? 8'h00 : lane_get(wbm_dat_i, lane);
    end
    ready_d = state_d == IDLE;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      lane      <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_d;
      req_ready <= ready_d;
      wbm_cyc_o <= cyc_d;
      wbm_stb_o <= cyc_d;
      wbm_we_o  <= we_d;
      wbm_adr_o <= adr_d;
      wbm_dat_o <= dat_d;
      wbm_sel_o <= sel_d;
      lane      <= lane_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rdata_d;
    end
endmodule

// File: tb/tb_wb_host_bridge.sv
// tb_wb_host_bridge: table-driven, hand-sequenced and randomized checks of wb_host_bridge
module tb_wb_host_bridge;
  localparam int TMO = 8;
  localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_NONE = 3;
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          waits;
    int          kind;
    logic [31:0] bus;
    logic [31:0] e_adr;
    logic [3:0]  e_sel;
    logic [31:0] e_dat;
    logic        e_err;
    logic [7:0]  e_rdata;
    int          e_cyc;
  } vec_t;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_we = 0;
  logic [15:0] req_addr = 0;
  logic [7:0]  req_wdata = 0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i = 0;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i = 0, wbm_err_i = 0;
  int checks = 0, errors = 0;
  vec_t vecs[7];
  wb_host_bridge #(.BASE_ADDR(32'h3000_0000), .ADDR_W(16), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready();
    int k = 0;
    while (!req_ready && k < 20) begin
      step();
      k++;
    end
    chk("ready_wait", req_ready, 1);
  endtask
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit tmo = v.kind == K_NONE || v.waits >= TMO;
    r.e_adr   = 32'h3000_0000 | (32'(v.addr) / 4 * 4);
    r.e_sel   = 4'(1 << (v.addr % 4));
    r.e_dat   = 32'(v.wdata) * 32'h0101_0101;
    r.e_cyc   = tmo ? TMO : v.waits + 1;
    r.e_err   = tmo || v.kind != K_ACK;
    r.e_rdata = r.e_err ? 8'hFF : v.we ? 8'h00 : 8'(v.bus >> (8 * (v.addr % 4)));
    return r;
  endfunction
  task automatic run_txn(input vec_t v);
    int n = 0;
    wait_ready();
    req_valid = 1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    step();
    req_valid = 0;
    chk("cyc", wbm_cyc_o, 1);
    chk("stb", wbm_stb_o, 1);
    chk("adr", wbm_adr_o, v.e_adr);
    chk("sel", 32'(wbm_sel_o), 32'(v.e_sel));
    chk("dat", wbm_dat_o, v.e_dat);
    chk("we", wbm_we_o, 32'(v.we));
    do begin
      if (v.kind != K_NONE && n == v.waits) begin
        wbm_ack_i = v.kind == K_ACK || v.kind == K_BOTH;
        wbm_err_i = v.kind == K_ERR || v.kind == K_BOTH;
        wbm_dat_i = v.bus;
      end else wbm_dat_i = $urandom;
      step();
      wbm_ack_i = 0; wbm_err_i = 0;
      n++;
      if (wbm_stb_o) chk("adr_hold", wbm_adr_o, v.e_adr);
    end while (wbm_stb_o && n < 40);
    chk("bus_cycles", n, v.e_cyc);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, 32'(v.e_err));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(v.e_rdata));
    chk("ready_after", req_ready, 1);
    chk("cyc_drop", wbm_cyc_o, 0);
    step();
    chk("rsp_pulse", rsp_valid, 0);
    chk("rdata_hold", 32'(rsp_rdata), 32'(v.e_rdata));
    chk("err_hold", rsp_err, 32'(v.e_err));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t rv;
    vecs[0] = '{1'b1, 16'h0012, 8'hA5, 0, K_ACK, 32'h0, 32'h3000_0010, 4'b0100, 32'hA5A5_A5A5, 1'b0, 8'h00, 1};
    vecs[1] = '{1'b0, 16'h0007, 8'h00, 3, K_ACK, 32'h1122_3344, 32'h3000_0004, 4'b1000, 32'h0, 1'b0, 8'h11, 4};
    vecs[2] = '{1'b0, 16'h0000, 8'h3C, 0, K_NONE, 32'h0, 32'h3000_0000, 4'b0001, 32'h3C3C_3C3C, 1'b1, 8'hFF, 8};
    vecs[3] = '{1'b0, 16'h0001, 8'h00, 1, K_BOTH, 32'h1122_3344, 32'h3000_0000, 4'b0010, 32'h0, 1'b1, 8'hFF, 2};
    vecs[4] = '{1'b0, 16'hFFFF, 8'h00, 7, K_ACK, 32'hDEAD_BEEF, 32'h3000_FFFC, 4'b1000, 32'h0, 1'b0, 8'hDE, 8};
    vecs[5] = '{1'b0, 16'h0002, 8'h00, 8, K_ACK, 32'h1234_5678, 32'h3000_0000, 4'b0100, 32'h0, 1'b1, 8'hFF, 8};
    vecs[6] = '{1'b1, 16'h0003, 8'h5A, 2, K_ERR, 32'h0, 32'h3000_0000, 4'b1000, 32'h5A5A_5A5A, 1'b1, 8'hFF, 3};
    #3;
    chk("rst_ready", req_ready, 0);
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_adr", wbm_adr_o, 0);
    step();
    step();
    rst = 0;
    chk("rel_ready0", req_ready, 0);
    step();
    chk("rel_ready1", req_ready, 1);
    foreach (vecs[i]) run_txn(vecs[i]);
    wbm_ack_i = 1; wbm_err_i = 1;
    step();
    wbm_ack_i = 0; wbm_err_i = 0;
    chk("stray_rsp", rsp_valid, 0);
    chk("stray_cyc", wbm_cyc_o, 0);
    chk("stray_ready", req_ready, 1);
    wait_ready();
    req_valid = 1; req_we = 0; req_addr = 16'h0005;
    step();
    req_valid = 0;
    chk("mid_cyc", wbm_cyc_o, 1);
    step();
    rst = 1;
    #1;
    chk("mid_rst_cyc", wbm_cyc_o, 0);
    chk("mid_rst_stb", wbm_stb_o, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    step();
    step();
    rst = 0;
    chk("mid_rel_rsp", rsp_valid, 0);
    step();
    chk("mid_rel_ready", req_ready, 1);
    chk("mid_rel_cyc", wbm_cyc_o, 0);
    chk("mid_rel_rsp2", rsp_valid, 0);
    req_valid = 1; req_we = 0; req_addr = 16'h0101;
    step();
    chk("b2b_cyc1", wbm_cyc_o, 1);
    chk("b2b_sel1", 32'(wbm_sel_o), 32'b0010);
    req_addr = 16'h0202;
    wbm_ack_i = 1; wbm_dat_i = 32'hAABB_CCDD;
    step();
    wbm_ack_i = 0;
    chk("b2b_rsp1", rsp_valid, 1);
    chk("b2b_rd1", 32'(rsp_rdata), 32'hCC);
    chk("b2b_ready", req_ready, 1);
    step();
    req_valid = 0;
    chk("b2b_cyc2", wbm_cyc_o, 1);
    chk("b2b_sel2", 32'(wbm_sel_o), 32'b0100);
    chk("b2b_adr2", wbm_adr_o, 32'h3000_0200);
    chk("b2b_gap", rsp_valid, 0);
    wbm_ack_i = 1; wbm_dat_i = 32'h0102_0304;
    step();
    wbm_ack_i = 0;
    chk("b2b_rsp2", rsp_valid, 1);
    chk("b2b_rd2", 32'(rsp_rdata), 32'h02);
    step();
    for (int i = 0; i < 40; i++) begin
      rv.we    = 1'($urandom);
      rv.addr  = 16'($urandom);
      rv.wdata = 8'($urandom);
      rv.waits = int'($urandom_range(0, 9));
      rv.kind  = int'($urandom_range(0, 3));
      rv.bus   = $urandom;
      run_txn(model(rv));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
